// File: rtl/issue_rr_elastic_stage_pkg.sv
// Shared core constants for the issue / register-read boundary.
//   ISSUE_WIDTH      : default number of issue lanes
//   PAYLOAD_PKT_SIZE : default payload width, valid bit excluded
//   issue_pkt_t      : one payload packet at the default width
//   ptr_w()          : pointer width for a buffer of 'depth' entries (min 1)
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 4
`endif
`ifndef PAYLOAD_PKT_SIZE
`define PAYLOAD_PKT_SIZE 8
`endif

package issue_rr_elastic_stage_pkg;

    localparam int ISSUE_WIDTH      = `ISSUE_WIDTH;
    localparam int PAYLOAD_PKT_SIZE = `PAYLOAD_PKT_SIZE;

    typedef logic [PAYLOAD_PKT_SIZE-1:0] issue_pkt_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/issue_rr_elastic_stage_lane_fifo.sv
// issue_rr_lane_fifo: one lane's elastic buffer, DEPTH entries (any 1..8).
// Ports:
//   clk     : rising-edge clock
//   clr_i   : synchronous clear of pointers and count (reset/flush/inactive)
//   push_i  : write pkt_i at the tail (caller guarantees not full)
//   pop_i   : drop the head entry (caller guarantees not empty)
//   pkt_i   : packet to write
//   occ_o   : number of buffered entries
//   head_o  : entry at the read pointer (meaningful only when occ_o > 0)
module issue_rr_lane_fifo
    import issue_rr_elastic_stage_pkg::*;
#(
    parameter int PKT_W = PAYLOAD_PKT_SIZE,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [PKT_W-1:0]           pkt_i,
    output logic [$clog2(DEPTH+1)-1:0] occ_o,
    output logic [PKT_W-1:0]           head_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    occ_q, occ_d;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (push_i) wptr_d = wrap_inc(wptr_q);
            if (pop_i)  rptr_d = wrap_inc(rptr_q);
            case ({push_i, pop_i})
                2'b10:   occ_d = occ_q + CW'(1);
                2'b01:   occ_d = occ_q - CW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        occ_q  <= occ_d;
    end

    // Payload only written on push; no reset so it stays gateable.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= pkt_i;
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rptr_q];

endmodule

// File: rtl/issue_rr_elastic_stage.sv
// issue_rr_elastic_stage: per-lane elastic buffers between issue and
// register read. Lanes are independent FIFOs; no cross-lane reordering.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush_i         : discard everything buffered (push dropped)
//   laneActive_i    : per-lane enable; an inactive lane is held empty
//   valid_i/pkt_i   : issue-side packets, lane l at [l*PKT_W +: PKT_W]
//   ready_o         : lane can accept (state based, no path from ready_i)
//   valid_o/pkt_o   : head packet per lane, zero when not valid
//   ready_i         : register read consumes lane head
//   valid_bundle_o  : packet accepted on lane this cycle
//   occ_o           : per-lane occupancy, $clog2(DEPTH+1) bits per lane
module issue_rr_elastic_stage
    import issue_rr_elastic_stage_pkg::*;
#(
    parameter int LANES = ISSUE_WIDTH,
    parameter int PKT_W = PAYLOAD_PKT_SIZE,
    parameter int DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush_i,
    input  logic [LANES-1:0]                   laneActive_i,
    input  logic [LANES-1:0]                   valid_i,
    input  logic [LANES*PKT_W-1:0]             pkt_i,
    output logic [LANES-1:0]                   ready_o,
    output logic [LANES-1:0]                   valid_o,
    output logic [LANES*PKT_W-1:0]             pkt_o,
    input  logic [LANES-1:0]                   ready_i,
    output logic [LANES-1:0]                   valid_bundle_o,
    output logic [LANES*$clog2(DEPTH+1)-1:0]   occ_o
);

    localparam int CW = $clog2(DEPTH + 1);

    // Holds ready_o low for the first cycle after reset.
    logic rst_q;

    always_ff @(posedge clk) begin
        rst_q <= reset;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [CW-1:0]    occ;
        logic [PKT_W-1:0] head;
        logic             push, pop, clr;

        assign ready_o[l] = (occ < CW'(DEPTH)) & laneActive_i[l] & ~flush_i
                            & ~reset & ~rst_q;
        assign valid_o[l] = (occ != '0) & laneActive_i[l] & ~reset;
        assign push       = valid_i[l] & ready_o[l];
        assign pop        = valid_o[l] & ready_i[l];
        // Reset, flush and deactivation all empty the lane identically.
        assign clr        = reset | flush_i | ~laneActive_i[l];

        assign valid_bundle_o[l]        = push;
        assign pkt_o[l*PKT_W +: PKT_W]  = valid_o[l] ? head : '0;
        assign occ_o[l*CW +: CW]        = reset ? '0 : occ;

        issue_rr_lane_fifo #(
            .PKT_W (PKT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .clr_i  (clr),
            .push_i (push),
            .pop_i  (pop),
            .pkt_i  (pkt_i[l*PKT_W +: PKT_W]),
            .occ_o  (occ),
            .head_o (head)
        );
    end

endmodule

// File: doc/issue_rr_elastic_stage.md
ISSUE_RR_ELASTIC_STAGE -- requirements
Module: issue_rr_elastic_stage

Interface
REQ-001 SHALL have parameter LANES, default 4: number of issue lanes.
REQ-002 SHALL have parameter PKT_W, default `PAYLOAD_PKT_SIZE: payload packet width in bits, valid bit excluded.
REQ-003 SHALL have parameter DEPTH, default 2, legal 1..8, non-power-of-two allowed: per-lane buffer entries.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port flush_i, input, 1: discard all buffered packets.
REQ-007 SHALL have port laneActive_i, input, LANES: per-lane enable for dynamic width configuration.
REQ-008 SHALL have port valid_i, input, LANES: issue-side packet valid per lane.
REQ-009 SHALL have port pkt_i, input, LANES*PKT_W: issue-side packets; lane l occupies bits [l*PKT_W +: PKT_W].
REQ-010 SHALL have port ready_o, output, LANES: lane can accept a packet this cycle.
REQ-011 SHALL have port valid_o, output, LANES: register-read-side packet valid per lane.
REQ-012 SHALL have port pkt_o, output, LANES*PKT_W: head packet of each lane, using the same lane packing as pkt_i.
REQ-013 SHALL have port ready_i, input, LANES: register-read side consumes the head packet of lane l.
REQ-014 SHALL have port valid_bundle_o, output, LANES: per-lane accepted-this-cycle indication.
REQ-015 SHALL have port occ_o, output, LANES*$clog2(DEPTH+1): per-lane occupancy count.

Function
REQ-016 Each lane SHALL be an independent FIFO of DEPTH entries; lanes never exchange or reorder packets.
REQ-017 Push on lane l SHALL occur when valid_i[l] & ready_o[l].
REQ-018 Pop on lane l SHALL occur when valid_o[l] & ready_i[l].
REQ-019 ready_o[l] SHALL be (occ<DEPTH) & laneActive_i[l] & !flush_i, registered-state-based only, with no combinational path from ready_i.
REQ-020 A push and a pop on a full lane in the same cycle: no push, because ready_o=0; pop proceeds.
REQ-021 A push and a pop on a non-full, non-empty lane in the same cycle SHALL both occur, with occupancy unchanged.
REQ-022 Latency: a packet pushed at edge t SHALL appear on pkt_o/valid_o after edge t if the lane was empty, with no bypass in the same cycle.
REQ-023 valid_o[l] SHALL equal (occ>0) & laneActive_i[l].
REQ-024 pkt_o[l] SHALL be the head entry whenever valid_o[l]=1, and all-zero when valid_o[l]=0.
REQ-025 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-026 Occupancy SHALL saturate at neither bound: overflow and underflow are impossible by construction, and the bench asserts this.
REQ-027 valid_bundle_o[l] SHALL equal valid_i[l] & ready_o[l] (combinational).
REQ-028 flush_i=1 at an edge SHALL zero all occupancies and pointers; a flush has priority over a simultaneous push or pop, and the push is dropped.
REQ-029 laneActive_i[l]=0 at an edge SHALL empty lane l, discarding its contents; the lane's storage SHALL not be written while it is inactive.
REQ-030 Reactivating a lane SHALL start it empty, with no stale packets visible.
REQ-031 Payload storage SHALL be written only on push, which makes it clock-gating friendly; pointer and count registers are the only always-updated state.

Reset
REQ-032 reset=1 at an edge SHALL zero all pointers and occupancies; payload storage need not be cleared.
REQ-033 While reset=1, or during the first cycle after it: valid_o=0, pkt_o=0, ready_o=0, valid_bundle_o=0, occ_o=0.
REQ-034 reset asserted mid-operation SHALL discard all in-flight packets identically to flush; reset has priority over flush.

Structure
REQ-035 The default width and lane constants (`ISSUE_WIDTH, `PAYLOAD_PKT_SIZE) and the packet typedef SHALL come from the shared core package, with no local redefinition.
REQ-036 The per-lane FIFO SHALL be one sub-module, issue_rr_lane_fifo (params PKT_W, DEPTH), instantiated LANES times in a generate loop.
REQ-037 Flattening and unflattening of the packet arrays SHALL be done only in the top level.

Verification
REQ-038 The bench SHALL cover this scenario: LANES=4, DEPTH=2, ready_i=0, with lane0 pushing 0xA1, 0xA2, 0xA3 on consecutive cycles -> 0xA1 and 0xA2 are accepted, ready_o[0]=0 on the third cycle, occ=2, and 0xA3 is not accepted.
REQ-039 The bench SHALL cover this scenario: DEPTH=3, with a continuous push and ready_i=1 -> throughput of 1 per cycle, occ steady at 1, output order matches input order, and pointers wrap correctly past entry 2.
REQ-040 The bench SHALL cover this scenario: lane1 holds 2 packets, then flush_i=1 with valid_i[1]=1 -> the next cycle has occ=0, valid_o=0, and the pushed packet is absent.
REQ-041 The bench SHALL cover this scenario: laneActive_i=4'b1011 -> lane2 has ready_o=0, valid_o=0, valid_bundle_o[2]=0 for any valid_i; re-enabling it gives occ=0.
REQ-042 The bench SHALL cover this scenario: reset pulse for 1 cycle while all lanes are full -> all outputs are 0 the next cycle, and a push of 0x55 appears one cycle later.
REQ-043 The bench SHALL cover this scenario: DEPTH=1, full lane, ready_i=1 and valid_i=1 in the same cycle -> the head pops and the input is not accepted (ready_o=0); the input is accepted the following cycle.
